// File: rtl/bias_relu_if.sv
// Request/result bundle between the matmul stage and the bias+ReLU stage.
// Element 0 of every vector sits in the MSBs.
interface bias_relu_if #(
    parameter int S = 32,
    parameter int N = 4
);
    logic           start;
    logic [S*N-1:0] in_vec;
    logic [S*N-1:0] bias;
    logic [S*N-1:0] out_vec;
    logic           done;
    logic           busy;
    logic           err;

    modport master (output start, in_vec, bias, input out_vec, done, busy, err);
    modport slave  (input start, in_vec, bias, output out_vec, done, busy, err);
endinterface

// File: rtl/bias_relu_stage.sv
// Serialised bias-add + ReLU over one layer vector using one shared float adder.
// Optional leaky ReLU is enabled by defining BIAS_RELU_LEAKY_RELU_EN.
module add_float #(
    parameter int FLOAT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [FLOAT_WIDTH-1:0] a,
    input  logic [FLOAT_WIDTH-1:0] b,
    output logic [FLOAT_WIDTH-1:0] result,
    output logic                   done,
    output logic                   nan,
    output logic                   overflow
);
    logic [31:0] a_r, b_r, res_r, sum_s, big_s, sml_s;
    logic        pend_r, done_r, nan_r, ovf_r, nan_s, ovf_s;
    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, round_up_s;
    logic [7:0]  e_big_s, e_sml_s, dexp_s;
    logic [27:0] m_big_s, m_sml_s, m_sh_s, m_sum_s;
    logic [24:0] m_rnd_s;
    logic [9:0]  e_res_s;

    // IEEE-754 single add with round-to-nearest-even on the latched operands
    always_comb begin
        sum_s   = 32'h0000_0000;
        nan_s   = 1'b0;
        ovf_s   = 1'b0;
        a_nan_s = (&a_r[30:23]) && (|a_r[22:0]);
        b_nan_s = (&b_r[30:23]) && (|b_r[22:0]);
        a_inf_s = (&a_r[30:23]) && !(|a_r[22:0]);
        b_inf_s = (&b_r[30:23]) && !(|b_r[22:0]);
        if (a_r[30:0] >= b_r[30:0]) begin
            big_s = a_r;
            sml_s = b_r;
        end else begin
            big_s = b_r;
            sml_s = a_r;
        end
        e_big_s = (big_s[30:23] == 8'd0) ? 8'd1 : big_s[30:23];
        e_sml_s = (sml_s[30:23] == 8'd0) ? 8'd1 : sml_s[30:23];
        m_big_s = {1'b0, |big_s[30:23], big_s[22:0], 3'b000};
        m_sml_s = {1'b0, |sml_s[30:23], sml_s[22:0], 3'b000};
        dexp_s  = e_big_s - e_sml_s;
        if (dexp_s > 8'd27) begin
            m_sh_s = {27'd0, |m_sml_s};
        end else begin
            m_sh_s    = m_sml_s >> dexp_s;
            m_sh_s[0] = m_sh_s[0] | (|(m_sml_s & ~(28'hFFF_FFFF << dexp_s)));
        end
        m_sum_s = (big_s[31] == sml_s[31]) ? (m_big_s + m_sh_s) : (m_big_s - m_sh_s);
        e_res_s = {2'b00, e_big_s};
        if (m_sum_s[27]) begin
            m_sum_s = {1'b0, m_sum_s[27:2], m_sum_s[1] | m_sum_s[0]};
            e_res_s = e_res_s + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!m_sum_s[26] && (e_res_s > 10'd1)) begin
                    m_sum_s = m_sum_s << 1;
                    e_res_s = e_res_s - 10'd1;
                end
            end
        end
        round_up_s = m_sum_s[2] && (m_sum_s[1] || m_sum_s[0] || m_sum_s[3]);
        m_rnd_s    = {1'b0, m_sum_s[26:3]} + {24'd0, round_up_s};
        if (m_rnd_s[24]) begin
            m_rnd_s = m_rnd_s >> 1;
            e_res_s = e_res_s + 10'd1;
        end
        // a missing hidden bit means the result is subnormal (or zero)
        if (!m_rnd_s[23]) begin
            e_res_s = 10'd0;
        end
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_r[31] != b_r[31]))) begin
            sum_s = 32'h7FC0_0000;
            nan_s = 1'b1;
        end else if (a_inf_s) begin
            sum_s = a_r;
        end else if (b_inf_s) begin
            sum_s = b_r;
        end else if (m_rnd_s == 25'd0) begin
            sum_s = {big_s[31] & sml_s[31], 31'd0};
        end else if (e_res_s >= 10'd255) begin
            sum_s = {big_s[31], 8'hFF, 23'd0};
            ovf_s = 1'b1;
        end else begin
            sum_s = {big_s[31], e_res_s[7:0], m_rnd_s[22:0]};
        end
    end

    // operand capture on start, result and flags one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            res_r  <= 32'd0;
            pend_r <= 1'b0;
            done_r <= 1'b0;
            nan_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (start) begin
            a_r    <= a;
            b_r    <= b;
            pend_r <= 1'b1;
            done_r <= 1'b0;
        end else if (pend_r) begin
            res_r  <= sum_s;
            nan_r  <= nan_s;
            ovf_r  <= ovf_s;
            done_r <= 1'b1;
            pend_r <= 1'b0;
        end
    end

    assign result   = res_r;
    assign done     = done_r;
    assign nan      = nan_r;
    assign overflow = ovf_r;
endmodule

module bias_relu_stage #(
    parameter int S          = 32,
    parameter int N          = 4,
    parameter int LEAK_SHIFT = 3
) (
    input  logic         clk,
    input  logic         rst,
    bias_relu_if.slave   io
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] STORE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    if (S != 32 || N < 1 || LEAK_SHIFT < 1 || LEAK_SHIFT > 126) begin : g_bad_param
        $error("bias_relu_stage: unsupported S/N/LEAK_SHIFT");
    end

    logic [2:0]      state_r;
    logic [IDXW-1:0] idx_r;
    logic [S-1:0]    in_r   [N];
    logic [S-1:0]    bias_r [N];
    logic [S-1:0]    out_r  [N];
    logic [S-1:0]    sum_r, add_sum_s;
    logic            done_r, busy_r, err_r, add_start_r, add_rst_n_r;
    logic            add_arst_n_s, add_done_s, add_nan_s, add_ovf_s;

    function automatic logic [31:0] act(input logic [31:0] x);
        logic [31:0] y;
        if (!x[31] || ((&x[30:23]) && (|x[22:0]))) begin
            y = x;
        end else begin
`ifdef BIAS_RELU_LEAKY_RELU_EN
            if (&x[30:23]) begin
                y = x;
            end else if (x[30:23] <= 8'(LEAK_SHIFT)) begin
                y = 32'h8000_0000;
            end else begin
                y = {x[31], x[30:23] - 8'(LEAK_SHIFT), x[22:0]};
            end
`else
            y = 32'h0000_0000;
`endif
        end
        return y;
    endfunction

    // adder is held in reset outside ISSUE/WAIT and whenever the stage resets
    assign add_arst_n_s = ~rst & add_rst_n_r;

    add_float #(.FLOAT_WIDTH(S)) u_add (
        .clk      (clk),
        .rst_n    (add_arst_n_s),
        .start    (add_start_r),
        .a        (in_r[idx_r]),
        .b        (bias_r[idx_r]),
        .result   (add_sum_s),
        .done     (add_done_s),
        .nan      (add_nan_s),
        .overflow (add_ovf_s)
    );

    // sequencer: one element per ISSUE/WAIT/STORE pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= {IDXW{1'b0}};
            sum_r       <= {S{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            add_start_r <= 1'b0;
            add_rst_n_r <= 1'b0;
            for (int k = 0; k < N; k++) begin
                in_r[k]   <= {S{1'b0}};
                bias_r[k] <= {S{1'b0}};
                out_r[k]  <= {S{1'b0}};
            end
        end else begin
            add_start_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (io.start) begin
                        for (int k = 0; k < N; k++) begin
                            in_r[k]   <= io.in_vec[S*(N-1-k) +: S];
                            bias_r[k] <= io.bias[S*(N-1-k) +: S];
                        end
                        idx_r       <= {IDXW{1'b0}};
                        err_r       <= 1'b0;
                        done_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        add_rst_n_r <= 1'b1;
                        add_start_r <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: state_r <= WAIT;
                WAIT: begin
                    if (add_done_s) begin
                        sum_r       <= add_sum_s;
                        err_r       <= err_r | add_nan_s | add_ovf_s;
                        add_rst_n_r <= 1'b0;
                        state_r     <= STORE;
                    end
                end
                STORE: begin
                    out_r[idx_r] <= act(sum_r);
                    if (idx_r == IDXW'(N - 1)) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r       <= idx_r + IDXW'(1);
                        add_rst_n_r <= 1'b1;
                        add_start_r <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign io.out_vec[S*(N-1-g) +: S] = out_r[g];
    end
    assign io.done = done_r;
    assign io.busy = busy_r;
    assign io.err  = err_r;
endmodule
